reg_file_sb: RTL and testbench

- 16 x 16-bit register file with a pending-write scoreboard.
- It is the responder for the decode stage's read interface: decode presents p0_addr/p1_addr with re0/re1, and this block returns p0/p1 one cycle later.
- It accepts writeback from the end of the pipeline.
- It tracks registers with an in-flight write and raises stall when decode reads one of them.
- R14 is the data-segment base (ds) and R15 is the stack pointer (SP); both have programmable reset values.

---
 rtl/reg_file_sb.sv | 158 +++++++++++++++
 tb/tb_reg_file_sb.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// 16 x 16-bit register file with a pending-write scoreboard. It serves the
// decode stage's two read ports (data returned one cycle after the request),
// accepts writeback from the end of the pipeline, and tracks registers that
// have an in-flight write so decode can be stalled on a true hazard.
//
// R0 is hard-wired to zero. R14 (data-segment base) and R15 (stack pointer)
// have programmable reset values.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   re0/re1   in   read enables for ports 0/1
//   p0_addr   in   [3:0]  read address, port 0
//   p1_addr   in   [3:0]  read address, port 1
//   p0/p1     out  [15:0] registered read data
//   we        in   writeback enable
//   dst_addr  in   [3:0]  writeback register
//   dst       in   [15:0] writeback data
//   rsv       in   reserve request (marks rsv_addr busy)
//   rsv_addr  in   [3:0]  register to mark busy
//   stall     out  combinational; a read hits a pending, unbypassed write
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter logic [15:0] SP_INIT = 16'hFFFF,
  parameter logic [15:0] DS_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        re0,
  input  logic        re1,
  input  logic [3:0]  p0_addr,
  input  logic [3:0]  p1_addr,
  output logic [15:0] p0,
  output logic [15:0] p1,
  input  logic        we,
  input  logic [3:0]  dst_addr,
  input  logic [15:0] dst,
  input  logic        rsv,
  input  logic [3:0]  rsv_addr,
  output logic        stall
);

  // Current register contents, gathered from the per-register flops below.
  logic [15:0][15:0] reg_vals;

  logic [15:0] busy_q, busy_d;
  logic [15:0] p0_q, p0_d;
  logic [15:0] p1_q, p1_d;

  logic        wr_en;      // a write that actually lands in the array
  logic        hit0, hit1;
  logic [15:0] rd0, rd1;   // bypassed read values

  assign wr_en = we && (dst_addr != 4'd0);

  // ---------------------------------------------------------------------------
  // Register array: one flop group per register so each can carry its own
  // reset value. R0 never takes a write, so it stays at zero forever.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      localparam logic [15:0] RST_VAL = (gi == 15) ? SP_INIT :
                                        (gi == 14) ? DS_INIT : 16'h0000;
      logic [15:0] r_q, r_d;

      always_comb begin
        r_d = r_q;
        if ((gi != 0) && we && (dst_addr == 4'(gi))) begin
          r_d = dst;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= RST_VAL;
        end else begin
          r_q <= r_d;
        end
      end

      assign reg_vals[gi] = r_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read path with same-cycle writeback bypass (write-before-read).
  // ---------------------------------------------------------------------------
  always_comb begin
    rd0 = reg_vals[p0_addr];
    if (wr_en && (dst_addr == p0_addr)) begin
      rd0 = dst;
    end
    rd1 = reg_vals[p1_addr];
    if (wr_en && (dst_addr == p1_addr)) begin
      rd1 = dst;
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection. A read that the current writeback satisfies is not a
  // hazard even though the register is still marked busy this cycle.
  // busy_q[0] is never set, so reads of R0 never stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit0 = re0 && busy_q[p0_addr] && !(we && (dst_addr == p0_addr));
    hit1 = re1 && busy_q[p1_addr] && !(we && (dst_addr == p1_addr));
  end

  assign stall = hit0 | hit1;

  // ---------------------------------------------------------------------------
  // Scoreboard: clear on writeback first, then set on reserve, so a new
  // writer issued in the same cycle as the old writer retires keeps the
  // register busy. Reserves are dropped while stalled because decode will
  // present the same instruction again.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (we) begin
      busy_d[dst_addr] = 1'b0;
    end
    if (rsv && (rsv_addr != 4'd0) && !stall) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Read data registers hold when the port is idle or decode is stalled.
  always_comb begin
    p0_d = p0_q;
    p1_d = p1_q;
    if (re0 && !stall) begin
      p0_d = rd0;
    end
    if (re1 && !stall) begin
      p1_d = rd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 16'h0000;
      p0_q   <= 16'h0000;
      p1_q   <= 16'h0000;
    end else begin
      busy_q <= busy_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
    end
  end

  assign p0 = p0_q;
  assign p1 = p1_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Self-checking bench for reg_file_sb. A behavioural model (register array,
// busy set, expected read data) tracks the design; directed scenarios check
// concrete values, and a randomized run compares every cycle to the model.
// Inputs change on the falling edge; outputs are sampled away from the rising
// edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam logic [15:0] SP_V = 16'hFFFF;
  localparam logic [15:0] DS_V = 16'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        re0, re1;
  logic [3:0]  p0_addr, p1_addr;
  logic [15:0] p0, p1;
  logic        we;
  logic [3:0]  dst_addr;
  logic [15:0] dst;
  logic        rsv;
  logic [3:0]  rsv_addr;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_regs [16];
  bit          m_busy [16];
  logic [15:0] m_p0, m_p1;

  reg_file_sb #(.SP_INIT(SP_V), .DS_INIT(DS_V)) dut (
    .clk(clk), .rst(rst),
    .re0(re0), .re1(re1),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0(p0), .p1(p1),
    .we(we), .dst_addr(dst_addr), .dst(dst),
    .rsv(rsv), .rsv_addr(rsv_addr),
    .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: a read stalls when it targets a register with an outstanding
  // writer that the current writeback does not retire.
  function automatic bit m_stall();
    bit h0, h1;
    h0 = re0 && m_busy[p0_addr] && !(we && dst_addr == p0_addr);
    h1 = re1 && m_busy[p1_addr] && !(we && dst_addr == p1_addr);
    return h0 || h1;
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (we && dst_addr == a) return dst;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0000;
      m_busy[i] = 1'b0;
    end
    m_regs[14] = DS_V;
    m_regs[15] = SP_V;
    m_p0 = 16'h0000;
    m_p1 = 16'h0000;
  endtask

  task automatic idle();
    rst = 0; re0 = 0; re1 = 0; p0_addr = 0; p1_addr = 0;
    we = 0; dst_addr = 0; dst = 0; rsv = 0; rsv_addr = 0;
  endtask

  // One rising edge with the currently driven inputs; the model advances in
  // step. Returns at the following falling edge.
  task automatic tick();
    bit          st;
    logic [15:0] v0, v1;
    st = m_stall();
    v0 = m_read(p0_addr);
    v1 = m_read(p1_addr);
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else begin
      if (re0 && !st) m_p0 = v0;
      if (re1 && !st) m_p1 = v1;
      if (we && dst_addr != 0) m_regs[dst_addr] = dst;
      if (we) m_busy[dst_addr] = 1'b0;
      if (rsv && rsv_addr != 0 && !st) m_busy[rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    n_checks++;
    if (p0 !== 16'h0000 || p1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_pdata: p0=%h p1=%h required 0000 0000", p0, p1);
    end
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: stall=%b required 0", stall);
    end
    re0 = 1; p0_addr = 15; re1 = 1; p1_addr = 14;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read_stall: stall=%b required 0", stall);
    end
    tick();
    n_checks++;
    if (p0 !== 16'hFFFF || p1 !== 16'h1000) begin
      n_fail++;
      $display("FAIL reset_sp_ds: p0=%h p1=%h required FFFF 1000", p0, p1);
    end
    $display("test_reset: p0=%h p1=%h", p0, p1);
    idle();
  endtask

  task automatic test_write_read();
    we = 1; dst_addr = 3; dst = 16'h1234;
    tick();
    idle();
    re0 = 1; p0_addr = 3; re1 = 1; p1_addr = 3;
    tick();
    n_checks++;
    if (p0 !== 16'h1234 || p1 !== 16'h1234) begin
      n_fail++;
      $display("FAIL write_read_r3: p0=%h p1=%h required 1234 1234", p0, p1);
    end
    $display("test_write_read: R3 p0=%h p1=%h", p0, p1);
    idle();
    we = 1; dst_addr = 0; dst = 16'hBEEF;
    tick();
    idle();
    re0 = 1; p0_addr = 0;
    tick();
    n_checks++;
    if (p0 !== 16'h0000) begin
      n_fail++;
      $display("FAIL r0_write_ignored: p0=%h required 0000", p0);
    end
    $display("test_write_read: R0 p0=%h", p0);
    idle();
  endtask

  task automatic test_bypass();
    we = 1; dst_addr = 5; dst = 16'hA5A5; re0 = 1; p0_addr = 5;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_stall: stall=%b required 0", stall);
    end
    tick();
    n_checks++;
    if (p0 !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL bypass_data: p0=%h required A5A5", p0);
    end
    $display("test_bypass: p0=%h", p0);
    idle();
  endtask

  task automatic test_scoreboard();
    logic [15:0] old_p1;
    old_p1 = p1;
    rsv = 1; rsv_addr = 7;                       // cycle N
    tick();
    idle();
    re1 = 1; p1_addr = 7; rsv = 1; rsv_addr = 9; // cycle N+1
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_stall_r7: stall=%b required 1", stall);
    end
    tick();
    n_checks++;
    if (p1 !== old_p1) begin
      n_fail++;
      $display("FAIL sb_hold_p1: p1=%h required %h", p1, old_p1);
    end
    rsv = 0; rsv_addr = 0;                       // cycle N+2, still stalled
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_stall_hold: stall=%b required 1", stall);
    end
    tick();
    we = 1; dst_addr = 7; dst = 16'h0042;        // cycle N+3
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_release_stall: stall=%b required 0", stall);
    end
    tick();
    n_checks++;
    if (p1 !== 16'h0042) begin
      n_fail++;
      $display("FAIL sb_release_data: p1=%h required 0042", p1);
    end
    idle();
    re0 = 1; p0_addr = 9;                        // rsv to R9 was dropped
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_rsv_dropped: stall=%b required 0", stall);
    end
    tick();
    $display("test_scoreboard: p1=%h", p1);
    idle();
  endtask

  task automatic test_rsv_we_same();
    rsv = 1; rsv_addr = 4; we = 1; dst_addr = 4; dst = 16'h4444;
    tick();
    idle();
    re0 = 1; p0_addr = 4;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
        n_fail++;
        $display("FAIL rsv_we_busy: cycle %0d stall=%b required 1", k, stall);
      end
      tick();
    end
    we = 1; dst_addr = 4; dst = 16'h5555;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rsv_we_release: stall=%b required 0", stall);
    end
    tick();
    n_checks++;
    if (p0 !== 16'h5555) begin
      n_fail++;
      $display("FAIL rsv_we_data: p0=%h required 5555", p0);
    end
    $display("test_rsv_we_same: p0=%h", p0);
    idle();
  endtask

  task automatic test_reset_mid();
    // Leave nonzero data on the read ports first.
    we = 1; dst_addr = 2; dst = 16'h2222;
    re0 = 1; p0_addr = 2; re1 = 1; p1_addr = 15;
    tick();
    idle();
    rsv = 1; rsv_addr = 2;
    tick();
    rsv = 1; rsv_addr = 8;
    tick();
    idle();
    rst = 1; we = 1; dst_addr = 2; dst = 16'hDEAD;
    tick();
    idle();
    n_checks++;
    if (p0 !== 16'h0000 || p1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_pdata: p0=%h p1=%h required 0000 0000", p0, p1);
    end
    re0 = 1; p0_addr = 2; re1 = 1; p1_addr = 8;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_stall: stall=%b required 0", stall);
    end
    tick();
    n_checks++;
    if (p0 !== 16'h0000 || p1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_mid_regs: p0=%h p1=%h required 0000 0000", p0, p1);
    end
    $display("test_reset_mid: p0=%h p1=%h", p0, p1);
    idle();
  endtask

  task automatic test_random(input int n);
    bit exp_st;
    for (int i = 0; i < n; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      re0      = ($urandom_range(0, 3) != 0);
      re1      = ($urandom_range(0, 3) != 0);
      p0_addr  = 4'($urandom_range(0, 15));
      p1_addr  = 4'($urandom_range(0, 15));
      we       = ($urandom_range(0, 2) == 0);
      dst_addr = 4'($urandom_range(0, 15));
      dst      = 16'($urandom);
      rsv      = ($urandom_range(0, 3) == 0);
      rsv_addr = 4'($urandom_range(0, 15));
      exp_st   = m_stall();
      #1;
      n_checks++;
      if (stall !== exp_st) begin
        n_fail++;
        $display("FAIL rand_stall: cycle %0d stall=%b required %b", i, stall, exp_st);
      end
      tick();
      n_checks++;
      if (p0 !== m_p0 || p1 !== m_p1) begin
        n_fail++;
        $display("FAIL rand_pdata: cycle %0d p0=%h p1=%h required %h %h",
                 i, p0, p1, m_p0, m_p1);
      end
    end
    $display("test_random: %0d cycles", n);
    idle();
  endtask

  initial begin
    m_reset();
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_rsv_we_same();
    test_reset_mid();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
